// File: rtl/mmio_uart_led.sv
// I/O-page peripheral: LED register, 8N1 UART transmitter behind a small TX FIFO, and a status word.
// Latency: register reads are combinational; a UART_DATA store starts its frame on the second edge after the store.
// Backpressure: none toward the core; a store to a full FIFO is dropped and sets the sticky overflow flag.
module mmio_uart_led #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wmask,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic [4:0]  leds,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            baud_last;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, ovf_set, overflow;

  logic            sel, led_wr, stat_rd;
  logic [3:0]      idx;
  logic            unused;

  assign sel     = io_addr[22];
  assign idx     = io_addr[5:2];
  assign led_wr  = sel && (idx == 4'd1) && io_wmask[0];
  assign push_req = sel && (idx == 4'd2) && io_wmask[0];
  assign stat_rd = sel && (idx == 4'd4) && io_rstrb;
  assign unused  = ^{io_addr[31:23], io_addr[21:6], io_addr[1:0], io_wdata[31:8], io_wmask[3:1]};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == IDLE) && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign tx_busy    = !fifo_empty || (state != IDLE);
  assign baud_last  = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      leds     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A fresh overflow outranks the clear-on-read.
      if (ovf_set)      overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
      if (led_wr) leds <= io_wdata[4:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (baud_last) state_nxt = DATA;
      DATA:    if (baud_last && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (baud_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= fifo_mem[rd_ptr[AW-1:0]];
            baud  <= '0;
          end
        end
        START: begin
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud    <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          if (baud_last) baud <= '0;
          else           baud <= baud + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    io_rdata = '0;
    if (sel) begin
      case (idx)
        4'd1:    io_rdata = {27'b0, leds};
        4'd4:    io_rdata = {28'b0, overflow, fifo_empty, fifo_full, tx_busy};
        default: io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_led.sv
// Directed bench for mmio_uart_led with a 4-clock bit period and a 4-entry FIFO.
module tb_mmio_uart_led;

  localparam int CPB = 4;
  localparam logic [31:0] A_LED  = 32'h0040_0004;
  localparam logic [31:0] A_UART = 32'h0040_0008;
  localparam logic [31:0] A_STAT = 32'h0040_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [3:0]  io_wmask;
  logic        io_rstrb;
  logic [4:0]  leds;
  logic        uart_tx, tx_busy;

  int nvec = 0;
  int nmis = 0;

  mmio_uart_led #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_wmask(io_wmask), .io_rstrb(io_rstrb), .io_rdata(io_rdata),
    .leds(leds), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  vec_t vecs [13];
  logic [7:0] fill_bytes [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected line level for cycle j (0-based) of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j < CPB)          return 1'b0;
    else if (j < 9 * CPB) return b[(j - CPB) / CPB];
    else                  return 1'b1;
  endfunction

  // Next rising edge is the first START edge of the frame.
  task automatic expect_frame(input logic [7:0] b);
    for (int j = 0; j < 10 * CPB; j++) begin
      @(posedge clk); #1;
      check($sformatf("frame_%02h_tx[%0d]", b, j), {31'b0, uart_tx}, {31'b0, frame_bit(b, j)});
    end
  endtask

  task automatic idle_inputs();
    io_addr  = '0;
    io_wdata = '0;
    io_wmask = '0;
    io_rstrb = 1'b0;
  endtask

  task automatic stays_quiet(input string name, input int cycles);
    logic ok = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{A_LED,         32'h0000_000E, 4'b0001, 1'b0, 32'h0,  5'h0E};
    vecs[1]  = '{A_LED,         32'h0,         4'b0000, 1'b1, 32'hE,  5'h0E};
    vecs[2]  = '{A_LED,         32'h0000_001F, 4'b0010, 1'b0, 32'hE,  5'h0E};
    vecs[3]  = '{32'h0000_0004, 32'h0000_00FF, 4'b1111, 1'b0, 32'h0,  5'h0E};
    vecs[4]  = '{32'h0040_001C, 32'h0,         4'b0000, 1'b1, 32'h0,  5'h0E};
    vecs[5]  = '{A_STAT,        32'h0,         4'b0000, 1'b1, 32'h4,  5'h0E};
    vecs[6]  = '{A_LED,         32'hFFFF_FFE3, 4'b1111, 1'b0, 32'hE,  5'h03};
    vecs[7]  = '{32'hFFC0_0004, 32'h0,         4'b0000, 1'b1, 32'h3,  5'h03};
    vecs[8]  = '{32'h0040_000C, 32'h0000_001F, 4'b0001, 1'b0, 32'h0,  5'h03};
    vecs[9]  = '{A_UART,        32'h0,         4'b0000, 1'b1, 32'h0,  5'h03};
    vecs[10] = '{32'h0000_0010, 32'h0,         4'b0000, 1'b1, 32'h0,  5'h03};
    vecs[11] = '{32'h0040_0044, 32'h0000_0015, 4'b0001, 1'b0, 32'h3,  5'h15};
    vecs[12] = '{A_LED,         32'h0,         4'b0001, 1'b0, 32'h15, 5'h00};
    fill_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};

    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_leds", {27'b0, leds}, 32'h0);
    check("reset_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_busy", {31'b0, tx_busy}, 32'd0);
    io_addr = A_STAT;
    #1 check("reset_status", io_rdata, 32'h4);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      io_addr  = vecs[i].addr;
      io_wdata = vecs[i].wdata;
      io_wmask = vecs[i].wmask;
      io_rstrb = vecs[i].rstrb;
      #1 check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      @(posedge clk); #1;
      idle_inputs();
      check($sformatf("vec%0d_leds", i), {27'b0, leds}, {27'b0, vecs[i].exp_leds});
    end

    // Single byte 0xA5.
    io_addr = A_UART; io_wdata = 32'hA5; io_wmask = 4'b0001;
    @(posedge clk); #1;
    idle_inputs();
    check("a5_pre_start_tx", {31'b0, uart_tx}, 32'd1);
    check("a5_pre_start_busy", {31'b0, tx_busy}, 32'd1);
    expect_frame(8'hA5);
    @(posedge clk); #1;
    check("a5_after_tx", {31'b0, uart_tx}, 32'd1);
    check("a5_after_busy", {31'b0, tx_busy}, 32'd0);

    // Six stores on consecutive cycles, then a push into a full FIFO during a pop.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          io_addr = A_UART; io_wdata = i + 1; io_wmask = 4'b0001;
          @(posedge clk); #1;
        end
        idle_inputs();
        io_addr = A_STAT;
        #1 check("fill_status_ovf", io_rdata, 32'hB);
        io_rstrb = 1'b1;
        #1 check("fill_status_preclear", io_rdata, 32'hB);
        @(posedge clk); #1;
        io_rstrb = 1'b0;
        check("fill_status_cleared", io_rdata, 32'h3);
        repeat (35) @(posedge clk);
        #1 check("gap_status_full", io_rdata, 32'h3);
        io_addr = A_UART; io_wdata = 32'h07; io_wmask = 4'b0001;
        @(posedge clk); #1;
        idle_inputs();
        io_addr = A_STAT;
        #1 check("full_pop_push_no_ovf", io_rdata, 32'h3);
      end
      begin
        @(posedge clk); #1;
        check("fill_pre_start_tx", {31'b0, uart_tx}, 32'd1);
        for (int f = 0; f < 6; f++) begin
          if (f > 0) begin
            @(posedge clk); #1;
            check($sformatf("gap_before_%02h", fill_bytes[f]), {31'b0, uart_tx}, 32'd1);
          end
          expect_frame(fill_bytes[f]);
        end
        @(posedge clk); #1;
        check("fill_done_busy", {31'b0, tx_busy}, 32'd0);
      end
    join
    stays_quiet("dropped_byte_not_sent", 45);
    io_addr = A_STAT;
    #1 check("fill_end_status", io_rdata, 32'h4);
    idle_inputs();

    // Reset during bit 3 of 0x5A with 0x33 still queued.
    io_addr = A_LED; io_wdata = 32'h11; io_wmask = 4'b0001;
    @(posedge clk); #1;
    io_addr = A_UART; io_wdata = 32'h5A;
    @(posedge clk); #1;
    io_wdata = 32'h33;
    @(posedge clk); #1;
    idle_inputs();
    repeat (13) @(posedge clk);
    #1 check("5a_bit2_low", {31'b0, uart_tx}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("5a_bit3_high", {31'b0, uart_tx}, 32'd1);
    check("5a_busy_before_reset", {31'b0, tx_busy}, 32'd1);
    reset = 1'b0;
    io_addr = A_STAT;
    #1;
    check("midreset_tx", {31'b0, uart_tx}, 32'd1);
    check("midreset_busy", {31'b0, tx_busy}, 32'd0);
    check("midreset_leds", {27'b0, leds}, 32'h0);
    check("midreset_status", io_rdata, 32'h4);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    stays_quiet("no_frame_after_reset", 50);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mmio_uart_led.md
Name: mmio_uart_led

Overview:
- Memory-mapped I/O peripheral directly downstream of the single-cycle RISC-V core's data-memory port.
- Decodes core stores and loads in the I/O page, drives the 5-bit LED register, and serialises bytes to a UART TX line through a small FIFO.
- Reports status back on the load path so firmware can poll before writing.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥2.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- io_addr  input  32  core byte address; I/O page selected when io_addr[22]=1; register index = io_addr[5:2].
- io_wdata  input  32  core store data.
- io_wmask  input  4  core byte write mask; non-zero = store this cycle.
- io_rstrb  input  1  core load strobe this cycle.
- io_rdata  output  32  read data, combinational from io_addr.
- leds  output  5  LED register.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  FIFO non-empty or frame in progress.

Behaviour:
- Register map (io_addr[22]=1; index = io_addr[5:2]):
  - 1 = LED (R/W).
  - 2 = UART_DATA (W).
  - 4 = STATUS (R): bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow, upper bits 0.
- Accesses with io_addr[22]=0, or to any other index: writes ignored, io_rdata = 0.
- Reset (reset=0, async): leds=0, uart_tx=1, FIFO empty, overflow=0, FSM IDLE, bit/baud counters 0. Takes effect immediately, including mid-frame (uart_tx goes high without completing the frame).
- LED write: when io_wmask[0]=1, leds <= io_wdata[4:0] at the next edge. io_wmask[0]=0 leaves leds unchanged.
- UART_DATA write:
  - io_wmask[0]=1 pushes io_wdata[7:0] at the next edge.
  - If the FIFO is full and no pop occurs that same cycle, the byte is dropped and overflow is set (sticky).
  - If full with a simultaneous pop, the push is accepted.
- Write pulse: one push per cycle the write is presented. The core holds a store for exactly one cycle.
- STATUS read: any cycle with io_rstrb=1 at index 4 clears overflow at the next edge. io_rdata shows the pre-clear value. A new overflow event in the same cycle wins (overflow stays 1).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register, baud counter=0, go to START. No same-cycle bypass: a byte pushed into an empty FIFO is popped the following cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0]; after CLKS_PER_BIT cycles, shift right and increment the index. After bit 7's period, go to STOP. Order is LSB first.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back frames: each frame lasts 10·CLKS_PER_BIT cycles, plus one IDLE cycle between frames.
- Timing: first START cycle = 2 cycles after the write edge (push edge, then pop edge).
- FIFO: circular; pointers are log2(FIFO_DEPTH)+1 bits so wrap-around is unambiguous. full/empty are derived from the pointers.
- tx_busy = !fifo_empty || state != IDLE.
- Counters are sized $clog2(CLKS_PER_BIT). No combinational path from io_* to uart_tx.

Test Plan:
- Reset and LED: hold reset=0 for 2 cycles, check leds=0 and uart_tx=1. Release, store 0x0000000E to LED index 1 with wmask=4'b0001 → leds=5'h0E next edge. Read index 1 → io_rdata=0x0000000E.
- Single byte (CLKS_PER_BIT=4): write 0xA5 to UART_DATA.
  - uart_tx low for 4 cycles starting 2 cycles later.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each, then high for 4.
  - tx_busy falls after 40 cycles of frame.
- FIFO fill and overflow (DEPTH=4): write 6 bytes on consecutive cycles 0x01..0x06.
  - 0x01 is popped, so 0x02–0x05 are queued and 0x06 is dropped.
  - STATUS reads overflow=1, full=1.
  - Frames 0x01..0x05 appear in order with a 1-cycle IDLE gap.
- Overflow clear: after the above, read STATUS with io_rstrb → bit3=1 on that read, 0 on the next read.
- Reset mid-frame: assert reset during DATA bit 3 of 0x5A → uart_tx=1 immediately, FIFO empty, tx_busy=0. No residual frame after release.
- Decode miss: store 0xFF to index 1 with io_addr[22]=0 → leds unchanged. Read index 7 → io_rdata=0.
